// File: rtl/kws_decision.sv
// kws_decision
//   Post-softmax decision stage of the keyword-spotting pipeline. A packed
//   probability vector is captured when the block is idle, scanned serially
//   for its argmax, and the winning class is run through a confidence
//   threshold and a consecutive-frame debounce to produce a detect pulse.
//   Frames offered while a scan is in flight are dropped and counted.
//
// Ports
//   clk          : rising-edge clock
//   rst_n        : synchronous reset, active HIGH despite the name
//   data_in      : packed scores, element i at [i*ACTIV_BITS +: ACTIV_BITS]
//   data_valid   : data_in valid this cycle
//   in_ready     : block is idle and will accept a frame
//   class_idx    : argmax index of the last completed frame
//   class_score  : score at class_idx
//   result_valid : one-cycle pulse, class_idx/class_score/detect are new
//   detect       : one-cycle pulse, debounce streak just reached HOLD_COUNT
//   drop_count   : saturating count of frames dropped while busy
module kws_decision #(
  parameter int INPUT_SIZE = 10,
  parameter int ACTIV_BITS = 8,
  parameter int IDX_BITS   = 4,
  parameter int THRESHOLD  = 128,
  parameter int HOLD_COUNT = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [INPUT_SIZE*ACTIV_BITS-1:0] data_in,
  input  logic                             data_valid,
  output logic                             in_ready,
  output logic [IDX_BITS-1:0]              class_idx,
  output logic [ACTIV_BITS-1:0]            class_score,
  output logic                             result_valid,
  output logic                             detect,
  output logic [7:0]                       drop_count
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  localparam logic [7:0]            HOLD   = 8'(HOLD_COUNT);
  localparam logic [ACTIV_BITS-1:0] THRESH = ACTIV_BITS'(THRESHOLD);

  state_e                          state_q, state_d;
  logic [INPUT_SIZE*ACTIV_BITS-1:0] frame_q, frame_d;
  logic [ACTIV_BITS-1:0]           max_q, max_d;
  logic [IDX_BITS-1:0]             idx_q, idx_d;
  logic [IDX_BITS-1:0]             ptr_q, ptr_d;
  logic [IDX_BITS-1:0]             class_idx_q, class_idx_d;
  logic [ACTIV_BITS-1:0]           class_score_q, class_score_d;
  logic                            result_valid_q, result_valid_d;
  logic                            detect_q, detect_d;
  logic [7:0]                      drop_count_q, drop_count_d;
  logic [7:0]                      streak_q, streak_d;
  logic [IDX_BITS-1:0]             last_idx_q, last_idx_d;

  logic [ACTIV_BITS-1:0]           cur_elem;
  logic [ACTIV_BITS-1:0]           scan_max;
  logic [IDX_BITS-1:0]             scan_idx;
  logic                            last_elem;
  logic                            hit;

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q        <= IDLE;
      frame_q        <= '0;
      max_q          <= '0;
      idx_q          <= '0;
      ptr_q          <= '0;
      class_idx_q    <= '0;
      class_score_q  <= '0;
      result_valid_q <= 1'b0;
      detect_q       <= 1'b0;
      drop_count_q   <= '0;
      streak_q       <= '0;
      last_idx_q     <= '0;
    end else begin
      state_q        <= state_d;
      frame_q        <= frame_d;
      max_q          <= max_d;
      idx_q          <= idx_d;
      ptr_q          <= ptr_d;
      class_idx_q    <= class_idx_d;
      class_score_q  <= class_score_d;
      result_valid_q <= result_valid_d;
      detect_q       <= detect_d;
      drop_count_q   <= drop_count_d;
      streak_q       <= streak_d;
      last_idx_q     <= last_idx_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (data_valid) state_d = SCAN;
      SCAN:    if (last_elem)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Element select by pointer match keeps the mux free of out-of-range
  // indexing when IDX_BITS covers more codes than INPUT_SIZE.
  always_comb begin
    cur_elem = '0;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      if (ptr_q == IDX_BITS'(i)) cur_elem = frame_q[i*ACTIV_BITS +: ACTIV_BITS];
    end
    // Strictly greater so ties keep the lowest index.
    if (cur_elem > max_q) begin
      scan_max = cur_elem;
      scan_idx = ptr_q;
    end else begin
      scan_max = max_q;
      scan_idx = idx_q;
    end
    last_elem = (ptr_q == IDX_BITS'(INPUT_SIZE - 1));
    hit       = (scan_max >= THRESH);
  end

  // Datapath, debounce and drop counter.
  always_comb begin
    frame_d        = frame_q;
    max_d          = max_q;
    idx_d          = idx_q;
    ptr_d          = ptr_q;
    class_idx_d    = class_idx_q;
    class_score_d  = class_score_q;
    result_valid_d = 1'b0;
    detect_d       = 1'b0;
    drop_count_d   = drop_count_q;
    streak_d       = streak_q;
    last_idx_d     = last_idx_q;

    if (state_q == IDLE && data_valid) begin
      frame_d = data_in;
      max_d   = data_in[ACTIV_BITS-1:0];
      idx_d   = '0;
      ptr_d   = IDX_BITS'(1);
    end

    if (state_q == SCAN) begin
      max_d = scan_max;
      idx_d = scan_idx;
      ptr_d = ptr_q + IDX_BITS'(1);
      if (last_elem) begin
        class_idx_d    = scan_idx;
        class_score_d  = scan_max;
        result_valid_d = 1'b1;
        if (hit) begin
          if (streak_q != 8'd0 && scan_idx == last_idx_q) begin
            // Continuing streak: fire only on the step that reaches HOLD.
            if (streak_q < HOLD) begin
              streak_d = streak_q + 8'd1;
              detect_d = ((streak_q + 8'd1) == HOLD);
            end
          end else begin
            // New streak; fires immediately only when HOLD is 1.
            streak_d   = 8'd1;
            last_idx_d = scan_idx;
            detect_d   = (HOLD == 8'd1);
          end
        end else begin
          streak_d = 8'd0;
        end
      end
    end

    if (state_q != IDLE && data_valid && drop_count_q != 8'hFF) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  // Output logic.
  always_comb begin
    in_ready = (state_q == IDLE);
  end

  assign class_idx    = class_idx_q;
  assign class_score  = class_score_q;
  assign result_valid = result_valid_q;
  assign detect       = detect_q;
  assign drop_count   = drop_count_q;

endmodule

// File: doc/kws_decision.md
# kws_decision

Post-softmax decision stage for the keyword-spotting pipeline. Sits directly downstream of the softmax stage and consumes its packed `INPUT_SIZE`-element probability vector on each `data_valid` pulse. It scans the vector serially to find the argmax class and its score. It then applies a confidence threshold and a consecutive-frame debounce, and emits a one-cycle keyword detection pulse. Frames arriving while a scan is in progress are dropped and counted, because the upstream stage has no backpressure.

## Interface

Parameters:
- `INPUT_SIZE`, 10: number of classes per vector; must be ≥ 2.
- `ACTIV_BITS`, 8: unsigned width of each score.
- `IDX_BITS`, 4: class index width; must be ≥ ceil(log2(`INPUT_SIZE`)).
- `THRESHOLD`, 128: minimum score, inclusive, for a frame to count as a hit.
- `HOLD_COUNT`, 3: consecutive same-class hits required to fire `detect`; must be ≥ 1 and < 256.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst_n`, in, 1: reset, synchronous and active-high. The port keeps the codebase reset name; the logic level 1 resets.
- `data_in`, in, `INPUT_SIZE*ACTIV_BITS`: packed scores; element i is at `[i*ACTIV_BITS +: ACTIV_BITS]`.
- `data_valid`, in, 1: `data_in` is valid this cycle.
- `in_ready`, out, 1: block is in IDLE and will accept a frame.
- `class_idx`, out, `IDX_BITS`: argmax index of the last completed frame.
- `class_score`, out, `ACTIV_BITS`: score at `class_idx`.
- `result_valid`, out, 1: one-cycle pulse; `class_idx`, `class_score` and `detect` are new this cycle.
- `detect`, out, 1: one-cycle pulse, coincident with `result_valid`; the debounce streak has just reached `HOLD_COUNT`.
- `drop_count`, out, 8: saturating count of frames dropped while busy.

## Operation

- FSM states: IDLE, SCAN, DONE.
- **IDLE.** `in_ready` = 1. On `data_valid`:
  - Capture `data_in` into a frame register.
  - Set the running max to element 0, running index to 0, pointer `ptr` to 1.
  - Go to SCAN.
- **SCAN.** `in_ready` = 0. Each cycle compares element `ptr` with the running max:
  - Unsigned compare. Strictly greater replaces the max, so ties keep the lowest index.
  - Increment `ptr`.
  - On the edge that processes `ptr` = `INPUT_SIZE-1`, register the final max/index into `class_score`/`class_idx`, update the debounce, drive `result_valid`/`detect`, and go to DONE.
- **DONE.** `in_ready` = 0. Lasts one cycle, then returns to IDLE.
- **Debounce**, evaluated with the final max/index; hit = score ≥ `THRESHOLD`:
  - Hit, `streak` > 0 and idx == `last_idx`: `streak` = min(`streak`+1, `HOLD_COUNT`).
  - Hit otherwise: `streak` = 1, `last_idx` = idx.
  - Not a hit: `streak` = 0 (`last_idx` unchanged).
  - `detect` = 1 only when `streak` transitions to `HOLD_COUNT` on this frame. Further hits at saturation do not re-fire.
  - With `HOLD_COUNT` = 1, every hit that starts a new streak fires.
- **Dropped frames.** `data_valid` while not in IDLE drops the frame; `drop_count` increments, saturating at 255. The in-flight scan is unaffected.
- The frame register is used only by the scan. `data_in` may change freely after capture.

## Timing

- Frame accepted on edge T, when IDLE and `data_valid`.
- SCAN covers edges T+1 … T+`INPUT_SIZE`-1.
- `result_valid` and `detect` are high in the cycle between edges T+`INPUT_SIZE`-1 and T+`INPUT_SIZE`. For the default of 10 classes, that is the cycle after edge T+9.
- `in_ready` is low from after edge T until after edge T+`INPUT_SIZE`. The earliest next accept is edge T+`INPUT_SIZE`+1.
- Throughput: one frame per `INPUT_SIZE`+1 cycles.
- `class_idx`/`class_score` hold their value until the next `result_valid`.
- **Reset:**
  - State → IDLE.
  - `in_ready` = 1.
  - `class_idx`, `class_score`, `result_valid`, `detect`, `drop_count`, `streak` and `last_idx` = 0.
- **Reset mid-SCAN or mid-DONE:** the frame is aborted with no `result_valid`; `in_ready` = 1 in the cycle after the reset edge; the streak is cleared.
- **`data_valid` on the DONE→IDLE edge:** dropped and counted, since acceptance requires the IDLE state.
- Reset has priority over all other events in the same cycle.

## Test plan

- **Reset.** Assert `rst_n` for 2 cycles → `in_ready` = 1 and every other output 0.
- **Basic argmax.** Defaults; scores {10,20,30,40,50,60,70,200,5,1}, accepted at edge T → one-cycle `result_valid` after edge T+9 with `class_idx` = 7, `class_score` = 200, `detect` = 0.
- **Tie-break.** Element 2 = 90 and element 5 = 90, all others < 90 → `class_idx` = 2, `class_score` = 90.
- **Debounce.** Four frames, each with idx 3 at score 150, then one frame with idx 3 at score 100 → `detect` pulses on frame 3 only and not on frame 4. Two further idx-3 frames at 150 produce no `detect`; the third does.
- **Drop while busy.** Pulse `data_valid` 4 cycles after an accept → `drop_count` = 1 and the in-flight result is unchanged. Pulse 300 times while busy → `drop_count` = 255.
- **Reset mid-SCAN.** Assert reset at edge T+5 → no `result_valid` for that frame, `in_ready` = 1 the next cycle, and a following idx-3 hit frame reports a streak of 1 (no early `detect`).
